// File: rtl/bus_pkg.sv
// bus_pkg: shared widths, FSM state type and request record for the serial-bus master port.
package bus_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, ARB, TX_ADDR, TX_DATA, WAIT_ACK, RX_DATA, RESP} master_state_t;
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/master_port_if.sv
// master_port_if: parallel request/response, arbitration and serial link of the master port.
interface master_port_if #(
  parameter int ADDR_W = bus_pkg::DEF_ADDR_W,
  parameter int DATA_W = bus_pkg::DEF_DATA_W
);
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              bus_req, bus_grant;
  logic              ser_out_valid, out_write, ser_addr, ser_wdata;
  logic              ser_in_valid, ser_rdata;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, bus_grant, ser_in_valid, ser_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, bus_req, ser_out_valid, out_write,
           ser_addr, ser_wdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, bus_grant, ser_in_valid, ser_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, bus_req, ser_out_valid, out_write,
           ser_addr, ser_wdata
  );
endinterface

// File: rtl/master_serdes.sv
// master_serdes: address/data shift registers with a shared bit counter and phase-done flag.
module master_serdes import bus_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              shift,
  input  logic              sel,
  input  logic              bit_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              addr_bit,
  output logic              data_bit,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);
  localparam int CW = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  // the data register shifts write bits out of bit 0 while read bits enter at the top
  always_comb begin
    cnt_d  = (load || clr) ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
    addr_d = load ? addr_in : (shift && !sel) ? addr_q >> 1 : addr_q;
    data_d = load ? data_in : (shift && sel) ? {bit_in, data_q[DATA_W-1:1]} : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  assign done     = cnt_q == (sel ? CW'(DATA_W - 1) : CW'(ADDR_W - 1));
  assign addr_bit = addr_q[0];
  assign data_bit = data_q[0];
  assign data_out = data_q;
endmodule

// File: rtl/master_port.sv
// master_port: parallel master to serial bus initiator; MASTER_PORT_TIMEOUT_EN adds a slave timeout.
module master_port import bus_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef MASTER_PORT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input logic          in_clk,
  input logic          reset,
  master_port_if.master bus
);
  master_state_t     state_q, state_d;
  logic              write_q, write_d, load, clr, shift, sel, addr_bit, data_bit, done, err, timeout;
  logic [DATA_W-1:0] data;
  master_serdes #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_serdes (
    .clk(in_clk), .rst(reset), .load, .clr, .shift, .sel, .bit_in(bus.ser_rdata),
    .addr_in(bus.req_addr), .data_in(bus.req_wdata), .addr_bit, .data_bit, .done, .data_out(data)
  );
`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          err_q, err_d, waiting;
  always_comb begin
    waiting = state_q == WAIT_ACK || state_q == RX_DATA;
    idle_d  = (waiting && !bus.ser_in_valid) ? idle_q + TW'(1) : '0;
    timeout = waiting && !bus.ser_in_valid && idle_q == TW'(TIMEOUT_CYCLES - 1);
    err_d   = state_q == IDLE ? 1'b0 : timeout ? 1'b1 : err_q;
  end
  always_ff @(posedge in_clk) begin
    if (reset) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    load    = 1'b0;
    clr     = 1'b0;
    shift   = 1'b0;
    sel     = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        load    = 1'b1;
        write_d = bus.req_write;
        state_d = ARB;
      end
      ARB: if (bus.bus_grant) begin
        clr     = 1'b1;
        state_d = TX_ADDR;
      end
      TX_ADDR: begin
        shift   = 1'b1;
        clr     = done;
        state_d = done ? (write_q ? TX_DATA : RX_DATA) : state_q;
      end
      TX_DATA: begin
        sel     = 1'b1;
        shift   = 1'b1;
        clr     = done;
        state_d = done ? WAIT_ACK : state_q;
      end
      WAIT_ACK: state_d = (bus.ser_in_valid || timeout) ? RESP : state_q;
      RX_DATA: begin
        sel     = 1'b1;
        shift   = bus.ser_in_valid;
        state_d = ((bus.ser_in_valid && done) || timeout) ? RESP : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge in_clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
    end
  end
  assign bus.req_ready     = state_q == IDLE;
  assign bus.bus_req       = state_q != IDLE;
  assign bus.ser_out_valid = state_q == TX_ADDR || state_q == TX_DATA;
  assign bus.out_write     = write_q && state_q != IDLE && state_q != ARB;
  assign bus.ser_addr      = state_q == TX_ADDR && addr_bit;
  assign bus.ser_wdata     = state_q == TX_DATA && data_bit;
  assign bus.resp_valid    = state_q == RESP;
  assign bus.resp_err      = state_q == RESP && err;
  assign bus.resp_rdata    = (state_q == RESP && !write_q && !err) ? data : '0;
endmodule

// File: tb/tb_master_port.sv
// tb_master_port: directed transactions against a cycle-by-cycle expected waveform of master_port.
module tb_master_port;
  import bus_pkg::*;
  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
`ifdef MASTER_PORT_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef MASTER_PORT_TIMEOUT_EN
  master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (.in_clk(clk), .reset(rst), .bus(bus));
`else
  master_port #(.ADDR_W(AW), .DATA_W(DW)) dut (.in_clk(clk), .reset(rst), .bus(bus));
`endif
  int checks = 0;
  int errors = 0;
  bit chk = 0;
  logic e_rdy, e_breq, e_sov, e_ow, e_sa, e_sw, e_rv, e_err;
  logic [DW-1:0] e_rd;
  int cyc_n = 0, t0 = 0, lat = 0, resp_n = 0, sov_n = 0;
  logic [DW-1:0] got_rd;
  logic got_err;
  logic [AW-1:0] sa_bits;
  logic [DW-1:0] sw_bits;

  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk) begin
    cmp("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    cmp("bus_req", 32'(bus.bus_req), 32'(e_breq));
    cmp("ser_out_valid", 32'(bus.ser_out_valid), 32'(e_sov));
    cmp("out_write", 32'(bus.out_write), 32'(e_ow));
    cmp("ser_addr", 32'(bus.ser_addr), 32'(e_sa));
    cmp("ser_wdata", 32'(bus.ser_wdata), 32'(e_sw));
    cmp("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
    cmp("resp_rdata", 32'(bus.resp_rdata), 32'(e_rd));
    cmp("resp_err", 32'(bus.resp_err), 32'(e_err));
  end

  always @(posedge clk) begin
    cyc_n++;
    if (!rst && bus.req_valid && bus.req_ready) begin
      t0 = cyc_n;
      resp_n = 0;
      sov_n = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.resp_valid) begin
      resp_n++;
      lat = cyc_n - t0;
      got_rd = bus.resp_rdata;
      got_err = bus.resp_err;
    end
    if (bus.ser_out_valid) begin
      if (sov_n < AW) sa_bits = {bus.ser_addr, sa_bits[AW-1:1]};
      else sw_bits = {bus.ser_wdata, sw_bits[DW-1:1]};
      sov_n++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic r, b, s, o, sa, sw, rv, input logic [DW-1:0] rd, input logic er);
    {e_rdy, e_breq, e_sov, e_ow, e_sa, e_sw, e_rv, e_rd, e_err} = {r, b, s, o, sa, sw, rv, rd, er};
  endtask

  // gap: idle slave cycles before read bit 1; ack_d < 0: never acknowledge; rst_at: address bit to reset on
  task automatic txn(input bus_req_t q, input int gd, input int ack_d, input logic [DW-1:0] rd,
                     input int gap, input int rst_at);
    logic to;
    int n;
    to = q.write && ack_d < 0;
    bus.ser_in_valid = 1'b1;
    bus.ser_rdata = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = q.write;
    bus.req_addr = q.addr;
    bus.req_wdata = q.wdata;
    ex(1, 0, 0, 0, 0, 0, 0, '0, 0);
    cyc();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i <= gd; i++) begin
      bus.bus_grant = (i == gd);
      ex(0, 1, 0, 0, 0, 0, 0, '0, 0);
      cyc();
    end
    bus.bus_grant = 1'b0;
    for (int i = 0; i < AW; i++) begin
      ex(0, 1, 1, q.write, q.addr[i], 0, 0, '0, 0);
      if (i == rst_at) rst = 1'b1;
      cyc();
      if (i == rst_at) begin
        rst = 1'b0;
        bus.ser_in_valid = 1'b0;
        ex(1, 0, 0, 0, 0, 0, 0, '0, 0);
        cyc();
        return;
      end
    end
    if (q.write) begin
      for (int i = 0; i < DW; i++) begin
        ex(0, 1, 1, 1, 0, q.wdata[i], 0, '0, 0);
        cyc();
      end
      n = to ? TO : ack_d + 1;
      for (int i = 0; i < n; i++) begin
        bus.ser_in_valid = (i == ack_d);
        ex(0, 1, 0, 1, 0, 0, 0, '0, 0);
        cyc();
      end
    end else begin
      for (int i = 0; i < DW; i++) begin
        if (i == 1) for (int g = 0; g < gap; g++) begin
          bus.ser_in_valid = 1'b0;
          bus.ser_rdata = 1'b1;
          ex(0, 1, 0, 0, 0, 0, 0, '0, 0);
          cyc();
        end
        bus.ser_in_valid = 1'b1;
        bus.ser_rdata = rd[i];
        ex(0, 1, 0, 0, 0, 0, 0, '0, 0);
        cyc();
      end
    end
    bus.ser_in_valid = 1'b1;
    ex(0, 1, 0, q.write, 0, 0, 1, (q.write || to) ? '0 : rd, to);
    cyc();
    bus.ser_in_valid = 1'b0;
  endtask

  task automatic chk_resp(input int l, input logic [DW-1:0] rd, input logic er);
    cmp("resp_count", resp_n, 1);
    cmp("latency", lat, l);
    cmp("rdata_literal", 32'(got_rd), 32'(rd));
    cmp("err_literal", 32'(got_err), 32'(er));
  endtask

  initial begin
    bus.req_valid = 0;
    bus.req_write = 0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.bus_grant = 0;
    bus.ser_in_valid = 0;
    bus.ser_rdata = 0;
    cyc();
    chk = 1;
    ex(1, 0, 0, 0, 0, 0, 0, '0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    txn('{1'b1, 12'hA5C, 8'h3E}, 0, 0, '0, 0, -1);
    chk_resp(22, 8'h00, 0);
    cmp("addr_bits", 32'(sa_bits), 32'h0000_0A5C);
    cmp("wdata_bits", 32'(sw_bits), 32'h0000_003E);
    txn('{1'b0, 12'h001, 8'h00}, 0, 0, 8'hC3, 0, -1);
    chk_resp(21, 8'hC3, 0);
    cmp("addr_bits_rd", 32'(sa_bits), 32'h0000_0001);
    txn('{1'b0, 12'h7F0, 8'hFF}, 0, 0, 8'h5A, 3, -1);
    chk_resp(24, 8'h5A, 0);
    txn('{1'b1, 12'h123, 8'h81}, 5, 2, '0, 0, -1);
    chk_resp(29, 8'h00, 0);
    cmp("wdata_bits_2", 32'(sw_bits), 32'h0000_0081);
    txn('{1'b1, 12'hFFF, 8'hFF}, 0, 0, '0, 0, 6);
    cmp("no_resp_after_reset", resp_n, 0);
    txn('{1'b0, 12'hABC, 8'h00}, 1, 0, 8'h01, 0, -1);
    chk_resp(22, 8'h01, 0);
`ifdef MASTER_PORT_TIMEOUT_EN
    txn('{1'b1, 12'h055, 8'hAA}, 0, -1, '0, 0, -1);
    chk_resp(37, 8'h00, 1);
`endif
    ex(1, 0, 0, 0, 0, 0, 0, '0, 0);
    cyc();
    cyc();
    chk = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
